// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer: sequences tagged packet bytes into the matcher bank (restore, stream, drain, eop) and collects per-packet results.
module dpi_stream_sequencer #(
    parameter int NUM_REGEX    = 8,
    parameter int LOAD_CYCLES  = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pkt_vld,
    input  logic                 pkt_sop,
    input  logic                 pkt_eop,
    input  logic [7:0]           pkt_data,
    input  logic [5:0]           pkt_sid,
    output logic                 pkt_rdy,
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_sid,
    input  logic [NUM_REGEX-1:0] cfg_enable,
    input  logic                 clear_streams,
    output logic                 load_state,
    output logic                 new_stream_id,
    output logic [5:0]           stream_id,
    output logic [NUM_REGEX-1:0] enable,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
    input  logic [NUM_REGEX-1:0] fired_in,
    output logic                 result_vld,
    output logic [5:0]           result_sid,
    output logic [NUM_REGEX-1:0] result_match,
    output logic [31:0]          pkt_count,
    output logic                 proto_err
);
    localparam int CNT_W = 8;
    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, EOP} state_t;
    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 start, stray, beat, first;
    logic [63:0]          seen;
    logic [NUM_REGEX-1:0] en_tbl [64];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pkt_rdy   = 1'b0;
        start     = 1'b0;
        stray     = 1'b0;
        case (state)
            IDLE: begin
                stray   = pkt_vld & ~pkt_sop;
                pkt_rdy = stray;
                start   = pkt_vld & pkt_sop;
                if (start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                if (cnt == CNT_W'(LOAD_CYCLES - 1)) state_nxt = STREAM;
                else cnt_nxt = cnt + CNT_W'(1);
            end
            STREAM: begin
                pkt_rdy = 1'b1;
                if (pkt_vld && pkt_eop) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(DRAIN_CYCLES)) state_nxt = EOP;
                else cnt_nxt = cnt + CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign beat = (state == STREAM) & pkt_vld;
    // restore handshake and held per-packet context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_state    <= 1'b0;
            new_stream_id <= 1'b0;
            stream_id     <= '0;
            enable        <= '0;
            first         <= 1'b0;
        end else begin
            load_state    <= start;
            new_stream_id <= start & ~seen[pkt_sid];
            if (start) begin
                stream_id <= pkt_sid;
                enable    <= en_tbl[pkt_sid];
            end
            first <= start ? 1'b1 : (beat ? 1'b0 : first);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_in     <= '0;
            char_in_vld <= 1'b0;
            eop         <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            char_in_vld <= beat;
            if (beat) char_in <= pkt_data;
            eop         <= (state == DRAIN) && (cnt == CNT_W'(DRAIN_CYCLES));
            proto_err   <= proto_err | stray | (beat & pkt_sop & ~first);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_vld   <= 1'b0;
            result_sid   <= '0;
            result_match <= '0;
            pkt_count    <= '0;
        end else begin
            result_vld <= (state == EOP);
            if (state == EOP) begin
                result_sid   <= stream_id;
                result_match <= fired_in & enable;
                pkt_count    <= pkt_count + 32'd1;
            end
        end
    end
    // a clear in the EOP cycle beats the seen-bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen <= '0;
        else if (clear_streams) seen <= '0;
        else if (state == EOP) seen[stream_id] <= 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) en_tbl[i] <= '0;
        end else if (cfg_we) begin
            en_tbl[cfg_sid] <= cfg_enable;
        end
    end
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb_dpi_stream_sequencer: directed packets against a per-cycle expectation timeline built from the sequencing rules.
module tb_dpi_stream_sequencer;
    localparam int LC = 3;
    localparam int DC = 3;
    localparam int MAXC = 2000;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pkt_vld = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
    logic [7:0] pkt_data = '0;
    logic [5:0] pkt_sid = '0;
    logic       pkt_rdy;
    logic       cfg_we = 1'b0;
    logic [5:0] cfg_sid = '0;
    logic [7:0] cfg_enable = '0;
    logic       clear_streams = 1'b0;
    logic       load_state, new_stream_id, char_in_vld, eop, result_vld, proto_err;
    logic [5:0] stream_id, result_sid;
    logic [7:0] enable, char_in, result_match;
    logic [7:0] fired_in = '0;
    logic [31:0] pkt_count;

    dpi_stream_sequencer #(.NUM_REGEX(8), .LOAD_CYCLES(LC), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .pkt_vld(pkt_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
        .pkt_data(pkt_data), .pkt_sid(pkt_sid), .pkt_rdy(pkt_rdy), .cfg_we(cfg_we),
        .cfg_sid(cfg_sid), .cfg_enable(cfg_enable), .clear_streams(clear_streams),
        .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
        .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
        .fired_in(fired_in), .result_vld(result_vld), .result_sid(result_sid),
        .result_match(result_match), .pkt_count(pkt_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;
    bit       exp_rdy [MAXC];
    bit       exp_load[MAXC];
    bit       exp_new [MAXC];
    bit [5:0] exp_sid [MAXC];
    bit [7:0] exp_en  [MAXC];
    bit       exp_cv  [MAXC];
    bit [7:0] exp_ch  [MAXC];
    bit       exp_eop [MAXC];
    bit       exp_rv  [MAXC];
    bit [5:0] exp_rs  [MAXC];
    bit [7:0] exp_rm  [MAXC];
    int       exp_cnt [MAXC];
    bit       exp_perr[MAXC];

    logic [63:0] m_seen = '0;
    logic [7:0]  m_en [64];
    int m_count = 0, m_idle = 0, m_lc = 0, m_fc = 0, m_lastc = 0, m_ec = 0;
    logic [7:0] pkt_q[$];
    int opt_gap, opt_abort;
    bit opt_mid_sop, opt_clr, opt_cfg;
    logic [7:0] opt_cfg_val, opt_fired;
    logic got;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (cyc > 0 && cyc < MAXC) begin
            chk("pkt_rdy", 32'(pkt_rdy), 32'(exp_rdy[cyc]));
            chk("load_state", 32'(load_state), 32'(exp_load[cyc]));
            chk("new_stream_id", 32'(new_stream_id), 32'(exp_new[cyc]));
            chk("stream_id", 32'(stream_id), 32'(exp_sid[cyc]));
            chk("enable", 32'(enable), 32'(exp_en[cyc]));
            chk("char_in_vld", 32'(char_in_vld), 32'(exp_cv[cyc]));
            if (exp_cv[cyc]) chk("char_in", 32'(char_in), 32'(exp_ch[cyc]));
            chk("eop", 32'(eop), 32'(exp_eop[cyc]));
            chk("result_vld", 32'(result_vld), 32'(exp_rv[cyc]));
            if (exp_rv[cyc]) begin
                chk("result_sid", 32'(result_sid), 32'(exp_rs[cyc]));
                chk("result_match", 32'(result_match), 32'(exp_rm[cyc]));
            end
            chk("pkt_count", pkt_count, exp_cnt[cyc]);
            chk("proto_err", 32'(proto_err), 32'(exp_perr[cyc]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic opts_default();
        opt_gap = 0; opt_abort = -1; opt_mid_sop = 0; opt_clr = 0;
        opt_cfg = 0; opt_cfg_val = '0; opt_fired = 8'hFF;
    endtask

    task automatic cfg(input logic [5:0] sid, input logic [7:0] val);
        cfg_we = 1'b1; cfg_sid = sid; cfg_enable = val; m_en[sid] = val;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_clear();
        clear_streams = 1'b1; m_seen = '0;
        step();
        clear_streams = 1'b0;
    endtask

    task automatic stray_byte(input logic [7:0] d);
        while (cyc < m_idle) step();
        pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = d;
        exp_rdy[cyc] = 1'b1;
        for (int k = cyc + 1; k < MAXC; k++) exp_perr[k] = 1'b1;
        step();
        pkt_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
        for (int k = cyc; k < MAXC; k++) begin
            exp_rdy[k] = 0; exp_load[k] = 0; exp_new[k] = 0; exp_sid[k] = 0; exp_en[k] = 0;
            exp_cv[k] = 0; exp_eop[k] = 0; exp_rv[k] = 0; exp_cnt[k] = 0; exp_perr[k] = 0;
        end
        m_seen = '0; m_count = 0;
        for (int i = 0; i < 64; i++) m_en[i] = '0;
        #1;
        chk("rst_char_in_vld", 32'(char_in_vld), 32'd0);
        chk("rst_stream_id", 32'(stream_id), 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        m_idle = cyc;
    endtask

    // drives pkt_q as one packet on sid and writes every output it must cause into the timeline
    task automatic send(input logic [5:0] sid, output logic got_new);
        int t, l, a, last, e, n;
        logic [7:0] cur_en;
        n = pkt_q.size();
        got_new = 1'bx;
        while (cyc < m_idle) step();
        t = cyc; l = t + 1;
        cur_en = m_en[sid];
        fired_in = opt_fired;
        pkt_sid = sid;
        exp_load[l] = 1'b1;
        exp_new[l] = ~m_seen[sid];
        for (int k = l; k < MAXC; k++) begin exp_sid[k] = sid; exp_en[k] = cur_en; end
        a = l + LC; last = a; m_lc = l;
        for (int i = 0; i < n; i++) begin
            if (i == opt_abort) begin
                do_reset();
                return;
            end
            pkt_vld = 1'b1;
            pkt_sop = (i == 0) || (opt_mid_sop && i == 1);
            pkt_data = pkt_q[i];
            pkt_eop = (i == n - 1);
            while (cyc < a) begin
                step();
                if (cyc == l) got_new = new_stream_id;
            end
            exp_rdy[a] = 1'b1; exp_cv[a+1] = 1'b1; exp_ch[a+1] = pkt_q[i]; last = a;
            if (i == 0) m_fc = a + 1;
            if (opt_mid_sop && i == 1) for (int k = a + 1; k < MAXC; k++) exp_perr[k] = 1'b1;
            if (i == 0 && opt_cfg) begin
                cfg_we = 1'b1; cfg_sid = sid; cfg_enable = opt_cfg_val; m_en[sid] = opt_cfg_val;
            end
            step();
            cfg_we = 1'b0;
            pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
            if (i < n - 1) repeat (opt_gap) begin exp_rdy[cyc] = 1'b1; step(); end
            a = cyc;
        end
        e = last + DC + 2;
        exp_eop[e] = 1'b1;
        exp_rv[e+1] = 1'b1; exp_rs[e+1] = sid; exp_rm[e+1] = opt_fired & cur_en;
        m_count++;
        for (int k = e + 1; k < MAXC; k++) exp_cnt[k] = m_count;
        while (cyc < e) step();
        if (opt_clr) begin clear_streams = 1'b1; m_seen = '0; end
        else m_seen[sid] = 1'b1;
        step();
        clear_streams = 1'b0;
        m_lastc = last + 1; m_ec = e; m_idle = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) m_en[i] = '0;
        opts_default();
        step(); step();
        chk("reset_load_state", 32'(load_state), 32'd0);
        chk("reset_pkt_count", pkt_count, 32'd0);
        chk("reset_proto_err", 32'(proto_err), 32'd0);
        rst_n = 1'b1;
        m_idle = cyc + 1;

        pkt_q = '{8'h55, 8'h53, 8'h45, 8'h52};
        send(6'd5, got);
        chk("new_sid5_first", 32'(got), 32'd1);
        chk("pin_first_char", m_fc - m_lc, 32'd4);
        chk("pin_eop", m_ec - m_lc, 32'd11);
        chk("first_result_sid", 32'(result_sid), 32'd5);
        chk("first_pkt_count", pkt_count, 32'd1);

        pkt_q = '{8'h01, 8'h02};
        send(6'd5, got);
        chk("new_sid5_repeat", 32'(got), 32'd0);
        do_clear();
        cfg(6'd5, 8'h0F);
        send(6'd5, got);
        chk("new_sid5_after_clear", 32'(got), 32'd1);
        chk("masked_match", 32'(result_match), 32'h0F);

        opt_cfg = 1; opt_cfg_val = 8'hF0;
        send(6'd5, got);
        chk("midpkt_cfg_old_enable", 32'(result_match), 32'h0F);
        opts_default();
        send(6'd5, got);
        chk("midpkt_cfg_next_pkt", 32'(result_match), 32'hF0);

        pkt_q = '{8'hA7};
        send(6'd12, got);
        chk("pin_single_drain", m_ec - m_lastc, 32'd4);
        pkt_q = '{8'h10, 8'h20, 8'h30};
        opt_gap = 2;
        send(6'd12, got);
        chk("new_sid12_b2b", 32'(got), 32'd0);
        opts_default();

        stray_byte(8'hEE);
        chk("stray_proto_err", 32'(proto_err), 32'd1);
        pkt_q = '{8'h41, 8'h42, 8'h43};
        opt_mid_sop = 1;
        send(6'd20, got);
        opts_default();
        chk("proto_err_sticky", 32'(proto_err), 32'd1);

        pkt_q = '{8'h61, 8'h62};
        opt_clr = 1;
        send(6'd30, got);
        opts_default();
        send(6'd30, got);
        chk("clear_beats_eop_set", 32'(got), 32'd1);

        pkt_q = '{8'h71, 8'h72, 8'h73, 8'h74};
        opt_abort = 2;
        send(6'd40, got);
        opts_default();
        pkt_q = '{8'h81, 8'h82};
        send(6'd5, got);
        chk("new_after_reset", 32'(got), 32'd1);
        chk("count_after_reset", pkt_count, 32'd1);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
